// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared frame state type, character constants and helpers for the UART command link
package uart_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGITS,
    ST_TERM,
    ST_COMMIT,
    ST_DISCARD
  } frame_state_t;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_L_UC = 8'h4C;
  localparam logic [7:0] CHAR_L_LC = 8'h6C;
  localparam logic [7:0] CHAR_E_UC = 8'h45;
  localparam logic [7:0] CHAR_E_LC = 8'h65;

  function automatic int hex_digits(input int width);
    return width / 4;
  endfunction

  localparam int LED_DIGITS     = hex_digits(16);
  localparam int ELEMENT_DIGITS = hex_digits(12);

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ascii_hex_nibble.sv
// rtl/ascii_hex_nibble.sv - combinational ASCII hex character to nibble converter
module ascii_hex_nibble (
  input  logic [7:0] i_char,
  output logic [3:0] o_nibble,
  output logic       o_is_hex
);

  always_comb begin
    o_nibble = 4'h0;
    o_is_hex = 1'b0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_nibble = 4'(i_char - 8'h30);
      o_is_hex = 1'b1;
    end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
      o_nibble = 4'(i_char - 8'h37);
      o_is_hex = 1'b1;
    end else if (i_char >= 8'h61 && i_char <= 8'h66) begin
      o_nibble = 4'(i_char - 8'h57);
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - parses 'L'/'E' ASCII hex frames from the UART RX stream into LED and element words
module uart_frame_decoder
  import uart_link_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int LED_COUNT      = 16,
  parameter int ELEMENT_COUNT  = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ena,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [LED_COUNT-1:0]     led_data,
  output logic [ELEMENT_COUNT-1:0] element_data,
  output logic                     led_update,
  output logic                     element_update,
  output logic                     frame_error,
  output logic [7:0]               error_count
);

  localparam int LED_DIG  = hex_digits(LED_COUNT);
  localparam int ELEM_DIG = hex_digits(ELEMENT_COUNT);
  localparam int MAX_DIG  = (LED_DIG > ELEM_DIG) ? LED_DIG : ELEM_DIG;
  localparam int SHIFT_W  = MAX_DIG * 4;
  localparam int DCNT_W   = $clog2(MAX_DIG + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  frame_state_t               r_state;
  logic                       r_is_led;
  logic [SHIFT_W-1:0]         r_shift;
  logic [DCNT_W-1:0]          r_digits;
  logic [TMO_W-1:0]           r_tmo;
  logic [LED_COUNT-1:0]       r_led_data;
  logic [ELEMENT_COUNT-1:0]   r_element_data;
  logic                       r_led_update;
  logic                       r_element_update;
  logic                       r_frame_error;
  logic [7:0]                 r_error_count;

  logic [7:0]                 w_char;
  logic [3:0]                 w_nibble;
  logic                       w_is_hex;
  logic                       w_is_term;
  logic                       w_is_l;
  logic                       w_is_e;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_in_frame;
  logic [DCNT_W-1:0]          w_last_digit;

  assign w_char       = rx_data[7:0];
  assign w_is_term    = (w_char == CHAR_CR) || (w_char == CHAR_LF);
  assign w_is_l       = (w_char == CHAR_L_UC) || (w_char == CHAR_L_LC);
  assign w_is_e       = (w_char == CHAR_E_UC) || (w_char == CHAR_E_LC);
  assign w_ready      = ena && (r_state != ST_COMMIT);
  assign w_accept     = rx_valid && w_ready;
  assign w_in_frame   = (r_state == ST_DIGITS) || (r_state == ST_TERM);
  assign w_last_digit = r_is_led ? DCNT_W'(LED_DIG - 1) : DCNT_W'(ELEM_DIG - 1);

  ascii_hex_nibble u_hex (
    .i_char   (w_char),
    .o_nibble (w_nibble),
    .o_is_hex (w_is_hex)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_is_led         <= 1'b0;
      r_shift          <= '0;
      r_digits         <= '0;
      r_tmo            <= '0;
      r_led_data       <= '0;
      r_element_data   <= '0;
      r_led_update     <= 1'b0;
      r_element_update <= 1'b0;
      r_frame_error    <= 1'b0;
      r_error_count    <= 8'd0;
    end else if (!ena) begin
      r_led_update     <= 1'b0;
      r_element_update <= 1'b0;
      r_frame_error    <= 1'b0;
    end else begin
      r_led_update     <= 1'b0;
      r_element_update <= 1'b0;
      r_frame_error    <= 1'b0;
      r_tmo            <= w_in_frame ? r_tmo + 1'b1 : '0;
      // A stalled frame is aborted even if a character lands on the same edge.
      if (w_in_frame && r_tmo == TMO_LAST) begin
        r_state       <= ST_IDLE;
        r_tmo         <= '0;
        r_frame_error <= 1'b1;
        r_error_count <= sat_inc8(r_error_count);
      end else if (r_state == ST_COMMIT) begin
        if (r_is_led) begin
          r_led_data   <= r_shift[LED_COUNT-1:0];
          r_led_update <= 1'b1;
        end else begin
          r_element_data   <= r_shift[ELEMENT_COUNT-1:0];
          r_element_update <= 1'b1;
        end
        r_state <= ST_IDLE;
      end else if (w_accept) begin
        r_tmo <= '0;
        case (r_state)
          ST_IDLE: begin
            if (w_is_l || w_is_e) begin
              r_is_led <= w_is_l;
              r_shift  <= '0;
              r_digits <= '0;
              r_state  <= ST_DIGITS;
            end else if (!w_is_term) begin
              r_frame_error <= 1'b1;
              r_error_count <= sat_inc8(r_error_count);
              r_state       <= ST_DISCARD;
            end
          end
          ST_DIGITS: begin
            if (w_is_hex) begin
              r_shift  <= {r_shift[SHIFT_W-5:0], w_nibble};
              r_digits <= r_digits + 1'b1;
              if (r_digits == w_last_digit) r_state <= ST_TERM;
            end else begin
              r_frame_error <= 1'b1;
              r_error_count <= sat_inc8(r_error_count);
              r_state       <= w_is_term ? ST_IDLE : ST_DISCARD;
            end
          end
          ST_TERM: begin
            if (w_is_term) begin
              r_state <= ST_COMMIT;
            end else begin
              r_frame_error <= 1'b1;
              r_error_count <= sat_inc8(r_error_count);
              r_state       <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (w_is_term) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_ready       = w_ready;
  assign led_data       = r_led_data;
  assign element_data   = r_element_data;
  assign led_update     = r_led_update;
  assign element_update = r_element_update;
  assign frame_error    = r_frame_error;
  assign error_count    = r_error_count;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - scoreboard bench for uart_frame_decoder
module tb_uart_frame_decoder;

  localparam int TMO = 100;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] led_data;
  logic [11:0] element_data;
  logic        led_update;
  logic        element_update;
  logic        frame_error;
  logic [7:0]  error_count;

  typedef struct {
    bit          is_led;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  int          errcnt_exp = 0;
  logic [15:0] led_exp = '0;
  logic [11:0] elem_exp = '0;

  uart_frame_decoder #(
    .DATA_WIDTH(8), .LED_COUNT(16), .ELEMENT_COUNT(12), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .led_data(led_data), .element_data(element_data),
    .led_update(led_update), .element_update(element_update),
    .frame_error(frame_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (led_update) begin
        if (sb_q.size() == 0) check_eq("led_update_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("led_update_kind", 1, 32'(e.is_led));
          check_eq("led_data", 32'(led_data), 32'(e.val));
        end
      end
      if (element_update) begin
        if (sb_q.size() == 0) check_eq("element_update_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("element_update_kind", 0, 32'(e.is_led));
          check_eq("element_data", 32'(element_data), 32'(e.val[11:0]));
        end
      end
      if (frame_error) err_seen++;
    end
  end

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = c;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("rx_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic expect_led(input logic [15:0] v);
    exp_t e;
    e.is_led = 1'b1;
    e.val    = v;
    sb_q.push_back(e);
    led_exp = v;
  endtask

  task automatic expect_elem(input logic [11:0] v);
    exp_t e;
    e.is_led = 1'b0;
    e.val    = {4'h0, v};
    sb_q.push_back(e);
    elem_exp = v;
  endtask

  task automatic expect_err();
    err_exp++;
    if (errcnt_exp < 255) errcnt_exp++;
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk);
    check_eq({tag, "_sb_drained"}, 32'(sb_q.size()), 0);
    check_eq({tag, "_led"}, 32'(led_data), 32'(led_exp));
    check_eq({tag, "_element"}, 32'(element_data), 32'(elem_exp));
    check_eq({tag, "_err_pulses"}, 32'(err_seen), 32'(err_exp));
    check_eq({tag, "_error_count"}, 32'(error_count), 32'(errcnt_exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("reset_led", 32'(led_data), 0);
    check_eq("reset_element", 32'(element_data), 0);
    check_eq("reset_error_count", 32'(error_count), 0);
    check_eq("reset_rx_ready", 32'(rx_ready), 1);

    expect_led(16'hA5C3);
    send_str("LA5C3");
    send_char(LF);
    settle("led_frame");

    expect_elem(12'h1F7);
    send_str("e1f7");
    send_char(CR);
    send_char(LF);
    settle("elem_crlf");

    send_str("L12");
    send_char(LF);
    expect_err();
    send_str("LG");
    expect_err();
    send_str("34");
    send_char(CR);
    settle("bad_frames");
    expect_led(16'h0001);
    send_str("L0001");
    send_char(LF);
    settle("after_discard");

    send_str("L12");
    repeat (TMO - 1) @(posedge clk);
    #1;
    check_eq("timeout_not_early", 32'(frame_error), 0);
    @(posedge clk);
    #1;
    check_eq("timeout_pulse", 32'(frame_error), 1);
    expect_err();
    settle("timeout");
    expect_elem(12'h00F);
    send_str("E00F");
    send_char(LF);
    settle("after_timeout");

    send_str("LFF");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_led", 32'(led_data), 0);
    check_eq("async_reset_element", 32'(element_data), 0);
    check_eq("async_reset_error_count", 32'(error_count), 0);
    led_exp = '0;
    elem_exp = '0;
    errcnt_exp = 0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_led(16'h0000);
    send_str("L0000");
    send_char(LF);
    settle("after_reset");

    send_str("L12");
    @(negedge clk);
    ena = 1'b0;
    rx_data = "3";
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("ena_low_rx_ready", 32'(rx_ready), 0);
      check_eq("ena_low_pulses", 32'({led_update, element_update, frame_error}), 0);
    end
    rx_valid = 1'b0;
    ena = 1'b1;
    expect_led(16'h1234);
    send_str("34");
    send_char(LF);
    settle("ena_resume");

    for (int i = 0; i < 300; i++) begin
      send_char("L");
      send_char(LF);
      expect_err();
      if (i == 254) check_eq("error_count_reach_255", 32'(error_count), 255);
    end
    settle("saturate");
    check_eq("error_count_saturated", 32'(error_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Receive-side counterpart of output_value_check: parses ASCII command frames from the UART RX byte stream back into LED and 7-segment element data.
- Sits between uart (rx_data/rx_valid/rx_ready) and the board-facing outputs.
- Frame format: type char, fixed count of hex digits (MSB nibble first), then terminator. LED frame is 'L' plus 4 hex digits. Element frame is 'E' plus 3 hex digits. Terminator is CR (0x0D) or LF (0x0A).
- Malformed, unterminated or stalled frames are discarded and counted.

Parameters:
DATA_WIDTH, 8, UART character width
LED_COUNT, 16, LED word width; LED frame carries LED_COUNT/4 hex digits
ELEMENT_COUNT, 12, element word width; element frame carries ELEMENT_COUNT/4 hex digits
TIMEOUT_CYCLES, 65535, maximum clocks between bytes inside a frame before abort

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, all state holds
rx_data  input  DATA_WIDTH  received character
rx_valid  input  1  rx_data valid
rx_ready  output  1  decoder accepts a character this cycle
led_data  output  LED_COUNT  last committed LED word
element_data  output  ELEMENT_COUNT  last committed element word
led_update  output  1  one-cycle pulse when led_data changes
element_update  output  1  one-cycle pulse when element_data changes
frame_error  output  1  one-cycle pulse on each discarded frame
error_count  output  8  saturating count of frame_error pulses

Behaviour:
- One clock (clk); reset_n is asynchronous, active-low. Reset mid-frame drops the partial frame. All outputs reset to 0, state to IDLE, timeout counter to 0.
- A character is accepted on a rising edge where rx_valid && rx_ready && ena. rx_ready = ena && (state != COMMIT).
- ena low: state, counters and data registers hold; pulses forced 0.
- Type and hex chars are case-insensitive. Hex set is 0-9, A-F, a-f.
- States:
  - IDLE: CR/LF are ignored (permits CRLF). 'L'/'E' latches the type, clears the shift register and digit count, then goes to DIGITS. Any other char pulses frame_error and goes to DISCARD.
  - DIGITS: a hex char shifts left 4 bits with the nibble in the LSBs and increments the digit count; the last digit goes to TERM. A terminator arriving early pulses frame_error and goes to IDLE. Any other char pulses frame_error and goes to DISCARD.
  - TERM: CR/LF goes to COMMIT. Any other char pulses frame_error and goes to DISCARD.
  - COMMIT (exactly 1 cycle, rx_ready=0): loads led_data or element_data from the shift register, asserts the matching *_update for 1 cycle, returns to IDLE.
  - DISCARD: swallows chars until CR/LF, then goes to IDLE with no extra error pulse.
- Latency: terminator accepted at edge k gives updated data and update pulse registered at edge k+1, visible during cycle k+1..k+2.
- Repeated identical frames still pulse *_update.
- Timeout: counter runs in DIGITS/TERM and is cleared on every accepted char and in all other states. Reaching TIMEOUT_CYCLES-1 pulses frame_error and goes to IDLE. The timeout takes priority over a char arriving on the same edge; that char is dropped.
- error_count increments on each frame_error and saturates at 255.
- Outputs are registered; no combinational path from rx_data to any output. rx_ready depends only on state and ena.

Decomposition:
- Shared package uart_link_pkg holds:
  - the state enum type;
  - constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_L/CHAR_E in both cases;
  - derived LED_DIGITS and ELEMENT_DIGITS.
- One sub-module, ascii_hex_nibble: combinational, 8-bit char in, 4-bit nibble plus is_hex flag out.
- The FSM, shift register and counters stay in uart_frame_decoder.

Test Plan:
- Reset then send "L","A","5","C","3",LF: led_data=16'hA5C3, led_update exactly 1 cycle, element_data=0, frame_error never high.
- Send "e","1","f","7",CR,LF: element_data=12'h1F7, one element_update pulse, trailing LF ignored, error_count=0.
- Send "L","1","2",LF then "L","G": one frame_error per frame, error_count=2, led_data unchanged. After "L","G", "3","4",CR is swallowed, then "L","0","0","0","1",LF gives led_data=1.
- Send "L","1","2" then idle TIMEOUT_CYCLES cycles: single frame_error, FSM in IDLE. Next "E","0","0","F",LF gives element_data=12'h00F.
- Assert reset_n low mid-frame after "L","F","F": outputs clear asynchronously. After release, "L","0","0","0","0",LF produces led_update with led_data=0.
- Hold ena low with rx_valid high for 10 cycles mid-frame: rx_ready=0, no state change. Completing the frame after ena returns commits the correct value. Force 300 errors: error_count saturates at 255.
